pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_ctrl_hazard_detect.sv | 16 +
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned PERF_W = 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparison between the ID-stage sources and an EX-stage load.
module hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              lu_stall
);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign lu_stall = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: boot bubbles, hazard priority and halt/drain.
// Optional performance counters are enabled with the PIPE_PERF_EN macro.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              halt,
    input  logic              resume,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              halted
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    localparam int unsigned BCNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    state_t            state;
    state_t            state_next;
    logic [BCNT_W-1:0] boot_cnt;
    logic              boot_done;
    logic              lu_stall;
    logic              mem_wait;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_stall    (lu_stall)
    );

    assign mem_wait  = mem_req && !mem_ready;
    // Last boot clock is the one where the counter reaches BOOT_CYCLES-1 (or at once for 0/1).
    assign boot_done = ((32'(boot_cnt) + 32'd1) >= BOOT_CYCLES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            boot_cnt <= '0;
        end else if ((state == BOOT) && !boot_done) begin
            boot_cnt <= boot_cnt + BCNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: if (boot_done) state_next = RUN;
            RUN:  if (halt && !mem_wait) state_next = HALT;
            HALT: if (resume) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // Control outputs; the defaults are the boot/reset bubble pattern.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_en    = 1'b0;
        idex_flush = 1'b1;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        halted     = 1'b0;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    ifid_flush = 1'b0;
                    idex_flush = 1'b0;
                end else if (ex_branch_taken) begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end else if (lu_stall) begin
                    // Hold PC and IF/ID; ID/EX loads a bubble while older stages advance.
                    ifid_flush = 1'b0;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b0;
                    idex_en    = 1'b1;
                    idex_flush = 1'b0;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end
            end
            HALT: begin
                ifid_flush = 1'b0;
                idex_flush = 1'b0;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                halted     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PIPE_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = (state == RUN) && (mem_wait || (!ex_branch_taken && lu_stall));
    assign flush_evt = (state == RUN) && !mem_wait && ex_branch_taken;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for RUN priorities plus boot/halt/mem-wait sequences.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    // Output bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted
    localparam logic [7:0] O_RESET  = 8'b0010_1000;
    localparam logic [7:0] O_NORMAL = 8'b1101_0110;
    localparam logic [7:0] O_LU     = 8'b0001_1110;
    localparam logic [7:0] O_BRANCH = 8'b1111_1110;
    localparam logic [7:0] O_FREEZE = 8'b0000_0000;
    localparam logic [7:0] O_HALT   = 8'b0000_0111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic       mem_req = 1'b0, mem_ready = 1'b0, halt = 1'b0, resume = 1'b0;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
    logic [7:0] outs;
`ifdef PIPE_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl #(.BOOT_CYCLES(2), .REG_AW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .halt            (halt),
        .resume          (resume),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .halted          (halted)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted};

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check8(input string nm, input logic [7:0] exp);
        n_cmp++;
        if (outs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, outs, exp);
        end
    endtask

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic mreq, input logic mrdy,
                         input logic h, input logic r);
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
        mem_req = mreq; mem_ready = mrdy; halt = h; resume = r;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] s0, f0;
        int exp_st, exp_fl;
        s0 = '0; f0 = '0; exp_st = 0; exp_fl = 0;

        vecs[0]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_NORMAL};
        vecs[1]  = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{5'd7,  5'd2,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[3]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_NORMAL};
        vecs[4]  = '{5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, O_NORMAL};
        vecs[5]  = '{5'd4,  5'd6,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_NORMAL};
        vecs[6]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, O_BRANCH};
        vecs[7]  = '{5'd3,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, O_BRANCH};
        vecs[8]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, O_FREEZE};
        vecs[9]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, O_FREEZE};
        vecs[10] = '{5'd9,  5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 1'b0, O_FREEZE};
        vecs[11] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, O_NORMAL};
        vecs[12] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, O_NORMAL};
        vecs[13] = '{5'd31, 5'd1,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};

        // Reset held for 3 cycles, then 2 boot cycles before RUN
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            #2 check8("reset_outs", O_RESET);
        end
        rst = 1'b1;
        #2 check8("boot_cycle1", O_RESET);
        tick();
        #2 check8("boot_cycle2", O_RESET);
        tick();
        #2 check8("run_after_boot", O_NORMAL);
`ifdef PIPE_PERF_EN
        check16("stall_cnt_after_reset", stall_cnt, 16'd0);
        check16("flush_cnt_after_reset", flush_cnt, 16'd0);
        s0 = stall_cnt; f0 = flush_cnt;
`endif

        // RUN priority table, one vector per cycle
        for (int i = 0; i < 14; i++) begin
            tick();
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].br,
                  vecs[i].mreq, vecs[i].mrdy, 1'b0, 1'b0);
            #2 check8($sformatf("vec%0d", i), vecs[i].exp);
            if (vecs[i].exp[7] == 1'b0) exp_st++;
            if (vecs[i].exp[5] == 1'b1) exp_fl++;
        end
        tick();
        idle();
        #2 check8("run_after_table", O_NORMAL);
`ifdef PIPE_PERF_EN
        check16("stall_cnt_table", stall_cnt, s0 + 16'(exp_st));
        check16("flush_cnt_table", flush_cnt, f0 + 16'(exp_fl));
        s0 = stall_cnt; f0 = flush_cnt;
`endif

        // Memory wait over a taken branch: freeze 4 cycles, branch on mem_ready
        for (int k = 0; k < 4; k++) begin
            tick();
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            #2 check8($sformatf("memwait_freeze%0d", k), O_FREEZE);
        end
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 check8("memwait_branch_release", O_BRANCH);
        tick();
        idle();
        #2 check8("memwait_after", O_NORMAL);
`ifdef PIPE_PERF_EN
        check16("stall_cnt_memwait", stall_cnt, s0 + 16'd4);
        check16("flush_cnt_memwait", flush_cnt, f0 + 16'd1);
`endif

        // Halt entry, drain, resume
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 check8("halt_request_cycle", O_NORMAL);
        tick();
        idle();
        #2 check8("halt_entered", O_HALT);
        tick();
        #2 check8("halt_held", O_HALT);
        tick();
        resume = 1'b1;
        #2 check8("halt_resume_cycle", O_HALT);
        tick();
        resume = 1'b0;
        #2 check8("resumed_run", O_NORMAL);

        // Resume in RUN is ignored; halt under memory wait does not halt
        tick();
        resume = 1'b1;
        #2 check8("resume_in_run", O_NORMAL);
        tick();
        resume = 1'b0;
        #2 check8("resume_in_run_next", O_NORMAL);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 check8("halt_during_memwait", O_FREEZE);
        tick();
        idle();
        #2 check8("no_halt_after_memwait", O_NORMAL);

        // Reset asserted mid-HALT
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        #2 check8("halt_again", O_HALT);
        #1 rst = 1'b0;
        #1 check8("reset_mid_halt", O_RESET);
`ifdef PIPE_PERF_EN
        check16("stall_cnt_cleared", stall_cnt, 16'd0);
        check16("flush_cnt_cleared", flush_cnt, 16'd0);
`endif
        tick();
        rst = 1'b1;
        #2 check8("reboot_cycle1", O_RESET);
        tick();
        #2 check8("reboot_cycle2", O_RESET);
        tick();
        #2 check8("reboot_run", O_NORMAL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
